// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, buffer entry layout, datapath width.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Redirect target: word address plus signed word offset, wrapping mod 2^32.
  function automatic logic [INSTR_W-1:0] branch_target(input logic [INSTR_W-1:0] base,
                                                       input logic [INSTR_W-1:0] delta);
    return base + delta;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of {pc, instr} with synchronous flush and
// simultaneous push/pop. Storage is reset so the head reads zero under reset.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic               empty,
  output logic               full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && do_push) begin
      mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one word read at a time, buffers returned words with
// their addresses for Decode, and handles Execute redirects, including dropping a
// read that was already in flight when the redirect arrived.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] exec_pc,
  input  logic [INSTR_W-1:0] delta_instruction,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_pc,
  input  logic               out_ready
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] target;
  logic               buf_empty;
  logic               buf_full;
  logic               push;
  logic               pop;

  assign target    = branch_target(exec_pc, delta_instruction);
  assign push      = (state == FS_WAIT) && imem_ack && !branch_taken;
  assign out_valid = !buf_empty && !branch_taken;
  assign pop       = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (branch_taken),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .empty      (buf_empty),
    .full       (buf_full)
  );

  // Fetch FSM with registered request/address; fetch_pc follows every redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      if (branch_taken) fetch_pc <= target;
      case (state)
        FS_IDLE: begin
          // A redirect flushes the buffer, so the target can be requested at once.
          if (branch_taken) begin
            imem_req  <= 1'b1;
            imem_addr <= target;
            state     <= FS_WAIT;
          end else if (!buf_full) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= FS_IDLE;
            if (!branch_taken) fetch_pc <= fetch_pc + 32'd1;
          end else if (branch_taken) begin
            state <= FS_DISCARD;
          end
        end
        FS_DISCARD: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= FS_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (RESET_PC=0, DEPTH=2).
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] exec_pc = '0;
  logic [31:0] delta_instruction = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  bit          auto_ack = 1'b0;
  bit          watch7 = 1'b0;
  bit          saw7 = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_taken      (branch_taken),
    .exec_pc           (exec_pc),
    .delta_instruction (delta_instruction),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .out_ready         (out_ready)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; sample 1ns after the edge, then let the memory model answer.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      imem_ack   = imem_req;
      imem_rdata = word_at(imem_addr);
    end
    if (watch7 && out_valid && out_pc == 32'd7) saw7 = 1'b1;
  endtask

  logic [31:0] req_addrs[$];

  initial begin
    // ---- Scenario 1: reset state and streaming fetch ----
    rst_n = 1'b0; out_ready = 1'b1; auto_ack = 1'b1;
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s1_req", 32'(imem_req), 32'd1);
      check("s1_addr", imem_addr, 32'(i));
      check("s1_valid_lo", 32'(out_valid), 32'd0);
      tick();
      check("s1_req_drop", 32'(imem_req), 32'd0);
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_pc", out_pc, 32'(i));
      check("s1_instr", out_instr, word_at(32'(i)));
    end

    // ---- Scenario 2: backpressure fills DEPTH=2 then stalls ----
    rst_n = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    req_addrs.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req && imem_ack) req_addrs.push_back(imem_addr);
    end
    check("s2_nreq", 32'(req_addrs.size()), 32'd2);
    check("s2_addr0", (req_addrs.size() > 0) ? req_addrs[0] : 32'hDEAD_BEEF, 32'd0);
    check("s2_addr1", (req_addrs.size() > 1) ? req_addrs[1] : 32'hDEAD_BEEF, 32'd1);
    check("s2_stall_req", 32'(imem_req), 32'd0);
    check("s2_head_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s2_after_pop_req", 32'(imem_req), 32'd0);
    check("s2_after_pop_head", out_pc, 32'd1);
    tick();
    check("s2_resume_req", 32'(imem_req), 32'd1);
    check("s2_resume_addr", imem_addr, 32'd2);
    tick();

    // ---- Scenario 3: branch while IDLE, 5 + (-3) = 2 ----
    check("s3_pre_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; exec_pc = 32'd5; delta_instruction = 32'hFFFF_FFFD;
    #1;
    check("s3_valid_masked", 32'(out_valid), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("s3_req", 32'(imem_req), 32'd1);
    check("s3_addr", imem_addr, 32'd2);
    check("s3_flushed", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    check("s3_valid", 32'(out_valid), 32'd1);
    check("s3_pc", out_pc, 32'd2);
    check("s3_instr", out_instr, word_at(32'd2));

    // ---- Scenario 4: branch in WAIT, late ack is discarded ----
    rst_n = 1'b0; auto_ack = 1'b0; imem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1; branch_taken = 1'b1; exec_pc = 32'd7; delta_instruction = 32'd0;
    tick();
    branch_taken = 1'b0;
    watch7 = 1'b1; saw7 = 1'b0;
    check("s4_req7", 32'(imem_req), 32'd1);
    check("s4_addr7", imem_addr, 32'd7);
    tick();
    branch_taken = 1'b1; exec_pc = 32'd20; delta_instruction = 32'd5;
    tick();
    branch_taken = 1'b0;
    check("s4_disc_req", 32'(imem_req), 32'd1);
    check("s4_disc_addr", imem_addr, 32'd7);
    tick(); tick();
    check("s4_hold_req", 32'(imem_req), 32'd1);
    check("s4_hold_addr", imem_addr, 32'd7);
    check("s4_hold_valid", 32'(out_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = word_at(32'd7);
    tick();
    imem_ack = 1'b0;
    check("s4_drop_req", 32'(imem_req), 32'd0);
    check("s4_drop_valid", 32'(out_valid), 32'd0);
    tick();
    check("s4_tgt_req", 32'(imem_req), 32'd1);
    check("s4_tgt_addr", imem_addr, 32'd25);
    imem_ack = 1'b1; imem_rdata = word_at(32'd25);
    tick();
    imem_ack = 1'b0;
    check("s4_valid", 32'(out_valid), 32'd1);
    check("s4_pc", out_pc, 32'd25);
    check("s4_instr", out_instr, word_at(32'd25));

    // ---- Scenario 5: branch and ack in the same cycle ----
    tick();
    check("s5_req", 32'(imem_req), 32'd1);
    check("s5_addr", imem_addr, 32'd26);
    branch_taken = 1'b1; exec_pc = 32'd100; delta_instruction = 32'd1;
    imem_ack = 1'b1; imem_rdata = word_at(32'd26);
    tick();
    branch_taken = 1'b0; imem_ack = 1'b0;
    check("s5_drop_req", 32'(imem_req), 32'd0);
    check("s5_drop_valid", 32'(out_valid), 32'd0);
    tick();
    check("s5_tgt_req", 32'(imem_req), 32'd1);
    check("s5_tgt_addr", imem_addr, 32'd101);
    imem_ack = 1'b1; imem_rdata = word_at(32'd101);
    tick();
    imem_ack = 1'b0;
    check("s5_valid", 32'(out_valid), 32'd1);
    check("s5_pc", out_pc, 32'd101);
    watch7 = 1'b0;
    check("s4_never_pc7", 32'(saw7), 32'd0);

    // ---- Scenario 6: reset mid-WAIT, late ack ignored ----
    tick();
    check("s6_req", 32'(imem_req), 32'd1);
    check("s6_addr", imem_addr, 32'd102);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = word_at(32'd102);
    #1;
    check("s6_rst_req", 32'(imem_req), 32'd0);
    check("s6_rst_addr", imem_addr, 32'h0);
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_pc", out_pc, 32'h0);
    check("s6_rst_instr", out_instr, 32'h0);
    tick();
    check("s6_rst_req2", 32'(imem_req), 32'd0);
    check("s6_rst_valid2", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("s6_first_req", 32'(imem_req), 32'd1);
    check("s6_first_addr", imem_addr, 32'h0);
    check("s6_ack_ignored", 32'(out_valid), 32'd0);
    imem_rdata = word_at(32'd0);
    tick();
    imem_ack = 1'b0;
    check("s6_valid", 32'(out_valid), 32'd1);
    check("s6_pc", out_pc, 32'h0);
    check("s6_instr", out_instr, word_at(32'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the word address fetched first after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the instruction buffer entry count (legal range 2..8).
REQ-003 The block SHALL run on one clock with asynchronous, active-low reset, through these ports:
 - clk  input  1  rising-edge clock.
 - rst_n  input  1  asynchronous active-low reset.
 - branch_taken  input  1  Execute global_disable; redirect request.
 - exec_pc  input  32  word address of the instruction now in Execute.
 - delta_instruction  input  32  signed word offset from Execute; valid when branch_taken=1.
 - imem_req  output  1  instruction memory read request.
 - imem_addr  output  32  word address of the request.
 - imem_ack  input  1  read data valid; completes the request.
 - imem_rdata  input  32  instruction word, valid with imem_ack.
 - out_valid  output  1  buffer head is valid for Decode.
 - out_instr  output  32  head instruction word.
 - out_pc  output  32  head word address.
 - out_ready  input  1  Decode accepts head.

Function
REQ-004 The block SHALL implement states IDLE, WAIT and DISCARD.
REQ-005 In IDLE with buffer count < DEPTH and branch_taken=0, the block SHALL assert imem_req with imem_addr=fetch_pc and move to WAIT.
REQ-006 imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1, with at most one request outstanding; imem_ack is ignored while imem_req=0.
REQ-007 On imem_ack in WAIT without branch_taken, the block SHALL push {fetch_pc, imem_rdata}, set fetch_pc=fetch_pc+1 (mod 2^32), drop imem_req the next cycle and return to IDLE.
REQ-008 When out_valid and out_ready are both 1, the head SHALL pop at the clock edge.
REQ-009 A push and a pop in the same cycle SHALL both take effect; count is unchanged.
REQ-010 A push SHALL never overflow, because issue requires count < DEPTH.
REQ-011 out_valid SHALL be 1 iff the buffer is non-empty and branch_taken=0; out_instr and out_pc SHALL show the head entry.
REQ-012 When branch_taken=1, the block SHALL, at that edge:
 - flush the buffer;
 - set fetch_pc=exec_pc+delta_instruction (32-bit two's-complement, wrap allowed);
 - suppress any pop.
REQ-013 On branch_taken in WAIT with imem_ack=0, the block SHALL go to DISCARD, holding imem_req and the old imem_addr.
REQ-014 On branch_taken in WAIT with imem_ack=1, the block SHALL drop the returned word and go to IDLE.
REQ-015 In DISCARD, the block SHALL drop the word on imem_ack and go to IDLE; a further branch_taken only updates fetch_pc.
REQ-016 Latency SHALL be:
 - first imem_req in the first cycle after rst_n deasserts;
 - imem_ack at cycle N gives out_valid at cycle N+1;
 - redirect gives imem_req for the target in the cycle after branch_taken (or after the discard ack).
REQ-017 With imem_ack returned the cycle after every request and out_ready=1, sustained throughput SHALL be one instruction every 2 cycles.

Reset
REQ-018 While rst_n=0, the block SHALL hold:
 - imem_req=0 and imem_addr=RESET_PC;
 - out_valid=0, out_instr=0, out_pc=0;
 - fetch_pc=RESET_PC, state IDLE, buffer empty.
REQ-019 A reset during WAIT or DISCARD SHALL abandon the request; a late imem_ack after reset is ignored unless a new request is outstanding.

Structure
REQ-020 The fetch state enum, INSTR_W=32 and the default RESET_PC SHALL be in the shared package cpu_pkg.
REQ-021 The buffer SHALL be a sub-module fetch_fifo with these properties:
 - parameterised depth;
 - synchronous flush;
 - simultaneous push/pop;
 - async active-low reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
 - Reset release, RESET_PC=0, ack one cycle after each request, out_ready=1 -> imem_addr sequence 0,1,2,3; out_pc sequence 0,1,2,3 with the matching rdata.
 - out_ready=0, DEPTH=2 -> exactly 2 requests (addr 0,1), then imem_req stays 0 until one pop.
 - branch_taken with exec_pc=5, delta=-3 (32'hFFFF_FFFD) while IDLE -> buffer empty; next imem_addr=2.
 - branch_taken in WAIT (addr 7 outstanding), ack 3 cycles later -> word at addr 7 dropped; next request addr=target; out_valid never shows pc 7.
 - branch_taken with imem_ack in the same cycle -> word dropped, state IDLE, next request at target.
 - rst_n asserted mid-WAIT, then released -> imem_req=0 and out_valid=0 during reset; first request after release at RESET_PC.
